// File: rtl/sw_pe_affine_track.sv
`timescale 1ns/1ps
// Smith-Waterman affine-gap processing element: one query row, two-stage pipeline with
// biased-zero saturating scores; chains the running best score and its column to the right.
module sw_pe_affine_track #(
    parameter int SCORE_WIDTH = 12,
    parameter int BASE_WIDTH  = 2,
    parameter int COL_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   query_ld,
    input  logic [BASE_WIDTH-1:0]  query_in,
    input  logic                   en_in,
    input  logic [BASE_WIDTH-1:0]  data_in,
    input  logic [SCORE_WIDTH-1:0] M_in,
    input  logic [SCORE_WIDTH-1:0] I_in,
    input  logic [SCORE_WIDTH-1:0] High_in,
    input  logic [COL_WIDTH-1:0]   Hcol_in,
    input  logic [SCORE_WIDTH-1:0] match,
    input  logic [SCORE_WIDTH-1:0] mismatch,
    input  logic [SCORE_WIDTH-1:0] gap_open,
    input  logic [SCORE_WIDTH-1:0] gap_extend,
    input  logic                   local_mode,
    output logic                   en_out,
    output logic [BASE_WIDTH-1:0]  data_out,
    output logic [SCORE_WIDTH-1:0] M_out,
    output logic [SCORE_WIDTH-1:0] I_out,
    output logic [SCORE_WIDTH-1:0] High_out,
    output logic [COL_WIDTH-1:0]   Hcol_out,
    output logic                   vld,
    output logic                   busy
);

    localparam int SW = SCORE_WIDTH;
    localparam int BW = BASE_WIDTH;
    localparam int CW = COL_WIDTH;
    localparam logic [SW-1:0] ZERO    = {1'b1, {(SW-1){1'b0}}};
    localparam logic [CW-1:0] COL_MAX = '1;
    localparam logic [CW-1:0] COL_ONE = {{(CW-1){1'b0}}, 1'b1};

    typedef logic signed [SW+1:0] wide_t;
    typedef enum logic {IDLE, CALC} state_t;

    function automatic wide_t ux(input logic [SW-1:0] v);
        return {2'b00, v};
    endfunction

    function automatic wide_t sx(input logic [SW-1:0] v);
        return {{2{v[SW-1]}}, v};
    endfunction

    // Sums never leave [-2^(SW), 2^(SW+1)), so the two top bits identify under/overflow.
    function automatic logic [SW-1:0] sat(input wide_t x);
        if (x[SW+1])
            return '0;
        else if (x[SW])
            return '1;
        else
            return x[SW-1:0];
    endfunction

    function automatic logic [SW-1:0] umax(input logic [SW-1:0] a, input logic [SW-1:0] b);
        return (a > b) ? a : b;
    endfunction

    state_t s1State_q, s1State_d;
    state_t s2State_q, s2State_d;
    logic   vld_q, vld_d;

    logic [BW-1:0] query_q;
    logic [SW-1:0] mDiag_q, iDiag_q;
    logic [SW-1:0] dR_q, uoR_q, ueR_q;
    logic [BW-1:0] data1_q;
    logic [SW-1:0] high1_q;
    logic [CW-1:0] hcol1_q;
    logic          first1_q;

    logic [SW-1:0] mOut_q, iOut_q, highOut_q, ownBest_q;
    logic [BW-1:0] dataOut_q;
    logic [CW-1:0] hcolOut_q, ownCol_q, colCnt_q;

    logic          s1Start;
    logic [SW-1:0] mDiag, iDiag, score, dR_d, uoR_d, ueR_d;

    logic [SW-1:0] mo, io, mNew, iNew, cand, ownPrev, ownNew, highNew;
    logic [CW-1:0] colCur, ownPrevCol, ownColNew, hcolNew;

    assign busy     = (s1State_q == CALC) || (s2State_q == CALC);
    assign en_out   = (s2State_q == CALC);
    assign vld      = vld_q;
    assign data_out = dataOut_q;
    assign M_out    = mOut_q;
    assign I_out    = iOut_q;
    assign High_out = highOut_q;
    assign Hcol_out = hcolOut_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1State_q <= IDLE;
            s2State_q <= IDLE;
            vld_q     <= 1'b0;
        end else begin
            s1State_q <= s1State_d;
            s2State_q <= s2State_d;
            vld_q     <= vld_d;
        end
    end

    // Stage 1: a column arriving after an idle cycle starts a fresh stream with ZERO diagonals.
    always_comb begin
        s1State_d = en_in ? CALC : IDLE;
        s1Start   = en_in && (s1State_q == IDLE);
        mDiag     = s1Start ? ZERO : mDiag_q;
        iDiag     = s1Start ? ZERO : iDiag_q;
        score     = (data_in == query_q) ? match : mismatch;
        dR_d      = sat(sx(score) + ux(umax(mDiag, iDiag)));
        uoR_d     = sat(ux(M_in) + sx(gap_open) + sx(gap_extend));
        ueR_d     = sat(ux(I_in) + sx(gap_extend));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            query_q  <= '0;
            mDiag_q  <= ZERO;
            iDiag_q  <= ZERO;
            dR_q     <= ZERO;
            uoR_q    <= ZERO;
            ueR_q    <= ZERO;
            data1_q  <= '0;
            high1_q  <= ZERO;
            hcol1_q  <= '0;
            first1_q <= 1'b0;
        end else begin
            if (query_ld && !busy && !en_in)
                query_q <= query_in;
            if (en_in) begin
                mDiag_q  <= M_in;
                iDiag_q  <= I_in;
                dR_q     <= dR_d;
                uoR_q    <= uoR_d;
                ueR_q    <= ueR_d;
                data1_q  <= data_in;
                high1_q  <= High_in;
                hcol1_q  <= Hcol_in;
                first1_q <= s1Start;
            end
        end
    end

    // Stage 2: own best only moves on a strict improvement; High_in wins ties.
    always_comb begin
        s2State_d  = (s1State_q == CALC) ? CALC : IDLE;
        vld_d      = (s2State_q == CALC) && (s1State_q == IDLE);
        mo         = first1_q ? ZERO : mOut_q;
        io         = first1_q ? ZERO : iOut_q;
        mNew       = (local_mode && (dR_q < ZERO)) ? ZERO : dR_q;
        iNew       = umax(umax(uoR_q, ueR_q),
                          umax(sat(ux(mo) + sx(gap_open) + sx(gap_extend)),
                               sat(ux(io) + sx(gap_extend))));
        cand       = umax(mNew, iNew);
        colCur     = '0;
        if (!first1_q)
            colCur = (colCnt_q == COL_MAX) ? COL_MAX : colCnt_q + COL_ONE;
        ownPrev    = first1_q ? ZERO : ownBest_q;
        ownPrevCol = first1_q ? '0 : ownCol_q;
        ownNew     = ownPrev;
        ownColNew  = ownPrevCol;
        if (cand > ownPrev) begin
            ownNew    = cand;
            ownColNew = colCur;
        end
        highNew = high1_q;
        hcolNew = hcol1_q;
        if (ownNew > high1_q) begin
            highNew = ownNew;
            hcolNew = ownColNew;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mOut_q    <= ZERO;
            iOut_q    <= ZERO;
            dataOut_q <= '0;
            highOut_q <= ZERO;
            hcolOut_q <= '0;
            ownBest_q <= ZERO;
            ownCol_q  <= '0;
            colCnt_q  <= '0;
        end else if (s1State_q == CALC) begin
            mOut_q    <= mNew;
            iOut_q    <= iNew;
            dataOut_q <= data1_q;
            highOut_q <= highNew;
            hcolOut_q <= hcolNew;
            ownBest_q <= ownNew;
            ownCol_q  <= ownColNew;
            colCnt_q  <= colCur;
        end else begin
            mOut_q    <= ZERO;
            iOut_q    <= ZERO;
            dataOut_q <= '0;
        end
    end

endmodule

// File: tb/tb_sw_pe_affine_track.sv
`timescale 1ns/1ps
// Bench for sw_pe_affine_track: directed columns with hand-computed scores go into a
// scoreboard that a negedge monitor drains whenever en_out or vld is presented.
module tb_sw_pe_affine_track;

    localparam logic [1:0] BASE_A = 2'd0;
    localparam logic [1:0] BASE_C = 2'd3;

    typedef struct packed {
        logic [1:0]  data;
        logic [11:0] m;
        logic [11:0] i;
    } colExp_t;

    typedef struct packed {
        logic [11:0] high;
        logic [15:0] hcol;
    } vldExp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        query_ld;
    logic [1:0]  query_in;
    logic        en_in;
    logic [1:0]  data_in;
    logic [11:0] M_in, I_in, High_in;
    logic [15:0] Hcol_in;
    logic [11:0] match, mismatch, gap_open, gap_extend;
    logic        local_mode;
    logic        en_out;
    logic [1:0]  data_out;
    logic [11:0] M_out, I_out, High_out;
    logic [15:0] Hcol_out;
    logic        vld;
    logic        busy;

    colExp_t colQ[$];
    vldExp_t vldQ[$];
    colExp_t colE;
    vldExp_t vldE;
    int      assertCount = 0;
    int      failCount   = 0;
    int      colIdx      = 0;
    int      vldIdx      = 0;

    sw_pe_affine_track dut (
        .clk        (clk),
        .rst        (rst),
        .query_ld   (query_ld),
        .query_in   (query_in),
        .en_in      (en_in),
        .data_in    (data_in),
        .M_in       (M_in),
        .I_in       (I_in),
        .High_in    (High_in),
        .Hcol_in    (Hcol_in),
        .match      (match),
        .mismatch   (mismatch),
        .gap_open   (gap_open),
        .gap_extend (gap_extend),
        .local_mode (local_mode),
        .en_out     (en_out),
        .data_out   (data_out),
        .M_out      (M_out),
        .I_out      (I_out),
        .High_out   (High_out),
        .Hcol_out   (Hcol_out),
        .vld        (vld),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic flagUnexpected(input string name);
        assertCount++;
        failCount++;
        $display("[TB] FAIL %s: output presented with nothing expected", name);
    endtask

    task automatic applyStimulus(input logic en, input logic [1:0] base, input logic [11:0] mIn,
                                 input logic [11:0] iIn, input logic [11:0] highIn, input logic [15:0] hcolIn);
        en_in   = en;
        data_in = base;
        M_in    = mIn;
        I_in    = iIn;
        High_in = highIn;
        Hcol_in = hcolIn;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            applyStimulus(1'b0, BASE_A, 12'd2048, 12'd2048, 12'd2048, 16'd0);
    endtask

    task automatic loadQuery(input logic [1:0] q);
        query_ld = 1'b1;
        query_in = q;
        applyStimulus(1'b0, BASE_A, 12'd2048, 12'd2048, 12'd2048, 16'd0);
        query_ld = 1'b0;
    endtask

    task automatic expectCol(input logic [1:0] d, input logic [11:0] m, input logic [11:0] i);
        colExp_t e;
        e.data = d;
        e.m    = m;
        e.i    = i;
        colQ.push_back(e);
    endtask

    task automatic expectVld(input logic [11:0] h, input logic [15:0] c);
        vldExp_t e;
        e.high = h;
        e.hcol = c;
        vldQ.push_back(e);
    endtask

    // Monitor: every presented column and every vld pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (en_out) begin
                if (colQ.size() == 0) begin
                    flagUnexpected("spuriousColumn");
                end else begin
                    colE = colQ.pop_front();
                    checkOutput($sformatf("colData[%0d]", colIdx), 32'(data_out), 32'(colE.data));
                    checkOutput($sformatf("colM[%0d]", colIdx), 32'(M_out), 32'(colE.m));
                    checkOutput($sformatf("colI[%0d]", colIdx), 32'(I_out), 32'(colE.i));
                    colIdx++;
                end
            end
            if (vld) begin
                if (vldQ.size() == 0) begin
                    flagUnexpected("spuriousVld");
                end else begin
                    vldE = vldQ.pop_front();
                    checkOutput($sformatf("vldHigh[%0d]", vldIdx), 32'(High_out), 32'(vldE.high));
                    checkOutput($sformatf("vldHcol[%0d]", vldIdx), 32'(Hcol_out), 32'(vldE.hcol));
                    checkOutput($sformatf("vldEnOut[%0d]", vldIdx), 32'(en_out), 32'd0);
                    vldIdx++;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst        = 1'b1;
        query_ld   = 1'b0;
        query_in   = BASE_A;
        en_in      = 1'b0;
        data_in    = BASE_A;
        M_in       = 12'd2048;
        I_in       = 12'd2048;
        High_in    = 12'd2048;
        Hcol_in    = 16'd0;
        match      = 12'd2;
        mismatch   = 12'hFFF;
        gap_open   = 12'hFFD;
        gap_extend = 12'hFFF;
        local_mode = 1'b1;

        #3;
        checkOutput("rstEnOut", 32'(en_out), 32'd0);
        checkOutput("rstVld", 32'(vld), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstMOut", 32'(M_out), 32'd2048);
        checkOutput("rstIOut", 32'(I_out), 32'd2048);
        checkOutput("rstHigh", 32'(High_out), 32'd2048);
        checkOutput("rstHcol", 32'(Hcol_out), 32'd0);
        checkOutput("rstData", 32'(data_out), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Asynchronous reset in the middle of a stream; only its first column is ever seen.
        loadQuery(BASE_C);
        expectCol(BASE_C, 12'd2050, 12'd2047);
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b1, BASE_C, 12'd2048, 12'd2048, 12'd2048, 16'd0);
        checkOutput("preRstHigh", 32'(High_out), 32'd2050);
        checkOutput("preRstData", 32'(data_out), 32'(BASE_C));
        en_in = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midRstEnOut", 32'(en_out), 32'd0);
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstMOut", 32'(M_out), 32'd2048);
        checkOutput("midRstIOut", 32'(I_out), 32'd2048);
        checkOutput("midRstHigh", 32'(High_out), 32'd2048);
        checkOutput("midRstHcol", 32'(Hcol_out), 32'd0);
        checkOutput("midRstData", 32'(data_out), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(6);

        // Query A against target AAA.
        loadQuery(BASE_A);
        for (int k = 0; k < 3; k++)
            expectCol(BASE_A, 12'd2050, 12'd2047);
        expectVld(12'd2050, 16'd0);
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b1, BASE_A, 12'd2048, 12'd2048, 12'd2048, 16'd0);
        checkOutput("busyMidStream", 32'(busy), 32'd1);
        idle(2);
        checkOutput("vldAtN5", 32'(vld), 32'd1);
        checkOutput("enOutAtN5", 32'(en_out), 32'd0);
        checkOutput("busyAtN5", 32'(busy), 32'd0);
        idle(3);

        // Mismatch in local mode clamps at ZERO; a tie hands High/Hcol from the left.
        expectCol(BASE_C, 12'd2048, 12'd2047);
        expectVld(12'd2048, 16'd5);
        applyStimulus(1'b1, BASE_C, 12'd2048, 12'd2048, 12'd2048, 16'd5);
        idle(4);
        local_mode = 1'b0;
        expectCol(BASE_C, 12'd2047, 12'd2047);
        expectVld(12'd2048, 16'd0);
        applyStimulus(1'b1, BASE_C, 12'd2048, 12'd2048, 12'd2048, 16'd0);
        idle(4);
        local_mode = 1'b1;

        // Saturation at the top of the range.
        expectCol(BASE_C, 12'd2048, 12'd4091);
        expectCol(BASE_A, 12'd4095, 12'd4090);
        expectVld(12'd4095, 16'd1);
        applyStimulus(1'b1, BASE_C, 12'd4095, 12'd2048, 12'd2048, 16'd0);
        applyStimulus(1'b1, BASE_A, 12'd2048, 12'd2048, 12'd2048, 16'd0);
        idle(4);

        // Saturation at the bottom of the range in global mode.
        local_mode = 1'b0;
        expectCol(BASE_A, 12'd2050, 12'd2047);
        expectCol(BASE_C, 12'd0, 12'd2046);
        expectVld(12'd2050, 16'd0);
        applyStimulus(1'b1, BASE_A, 12'd0, 12'd0, 12'd2048, 16'd0);
        applyStimulus(1'b1, BASE_C, 12'd0, 12'd0, 12'd2048, 16'd0);
        idle(4);
        local_mode = 1'b1;

        // Two streams separated by one idle cycle.
        expectCol(BASE_A, 12'd2050, 12'd2047);
        expectCol(BASE_C, 12'd2048, 12'd2047);
        expectCol(BASE_A, 12'd2050, 12'd2047);
        expectCol(BASE_A, 12'd2050, 12'd2996);
        expectVld(12'd2996, 16'd3);
        expectCol(BASE_C, 12'd2048, 12'd2047);
        expectCol(BASE_A, 12'd2050, 12'd2047);
        expectCol(BASE_C, 12'd2048, 12'd2047);
        expectVld(12'd2050, 16'd1);
        applyStimulus(1'b1, BASE_A, 12'd2048, 12'd2048, 12'd2048, 16'd0);
        applyStimulus(1'b1, BASE_C, 12'd2048, 12'd2048, 12'd2048, 16'd0);
        applyStimulus(1'b1, BASE_A, 12'd2048, 12'd2048, 12'd2048, 16'd0);
        applyStimulus(1'b1, BASE_A, 12'd3000, 12'd2048, 12'd2048, 16'd0);
        idle(1);
        applyStimulus(1'b1, BASE_C, 12'd2048, 12'd2048, 12'd2048, 16'd0);
        applyStimulus(1'b1, BASE_A, 12'd2048, 12'd2048, 12'd2048, 16'd0);
        applyStimulus(1'b1, BASE_C, 12'd2048, 12'd2048, 12'd2048, 16'd0);
        idle(4);

        // Query loads on the first column and while busy are ignored; left-hand best wins.
        query_ld = 1'b1;
        query_in = BASE_C;
        expectCol(BASE_C, 12'd2048, 12'd2047);
        expectCol(BASE_C, 12'd2048, 12'd2047);
        expectCol(BASE_A, 12'd2050, 12'd2047);
        expectVld(12'd3000, 16'd7);
        applyStimulus(1'b1, BASE_C, 12'd2048, 12'd2048, 12'd3000, 16'd7);
        applyStimulus(1'b1, BASE_C, 12'd2048, 12'd2048, 12'd3000, 16'd7);
        applyStimulus(1'b1, BASE_A, 12'd2048, 12'd2048, 12'd3000, 16'd7);
        query_ld = 1'b0;
        idle(5);
        checkOutput("holdHigh", 32'(High_out), 32'd3000);
        checkOutput("holdHcol", 32'(Hcol_out), 32'd7);
        checkOutput("idleMOut", 32'(M_out), 32'd2048);

        idle(3);
        checkOutput("colQueueDrained", 32'(colQ.size()), 32'd0);
        checkOutput("vldQueueDrained", 32'(vldQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
